// File: rtl/axi_bus_arbiter.sv
// Arbitrates the instruction and data read ports onto one AXI-style read bus and passes the data-port write through a separate write FSM.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin read arbitration (default build is fixed data-port priority).
module axi_bus_arbiter #(
  parameter int unsigned BEAT_CNT_W = 10
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [7:0]  i_rd_len,
  input  logic [1:0]  i_rd_step,
  output logic        i_rd_valid,
  output logic        i_rd_done,

  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic [7:0]  d_rd_len,
  input  logic [1:0]  d_rd_step,
  output logic        d_rd_valid,
  output logic        d_rd_done,

  output logic [31:0] rd_data,

  input  logic        d_wr_req,
  input  logic [31:0] d_wr_addr,
  input  logic [31:0] d_wr_data,
  input  logic [7:0]  d_wr_len,
  input  logic [1:0]  d_wr_step,
  output logic        d_wr_beat,
  output logic        d_wr_done,

  output logic        axi_ar_en,
  output logic [31:0] cpu_rd_addr,
  output logic [7:0]  ar_burst_len,
  output logic [1:0]  ar_burst_step,
  output logic        axi_aw_en,
  output logic [31:0] cpu_wr_addr,
  output logic [31:0] cpu_wr_data,
  output logic [7:0]  aw_burst_len,
  output logic [1:0]  aw_burst_step,

  input  logic [31:0] cpu_rd_data,
  input  logic        bus_rd_data_ready,
  input  logic        bus_wr_data_ready,
  input  logic        bus_wr_data_finish
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_BUSY = 2'd1,
    R_GAP  = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BUSY = 2'd1,
    W_GAP  = 2'd2
  } wr_state_t;

  rd_state_t               rd_state;
  wr_state_t               wr_state;
  logic                    grant_d;
  logic [BEAT_CNT_W-1:0]   rd_cnt;
  logic [BEAT_CNT_W-1:0]   rd_target;
  logic [BEAT_CNT_W-1:0]   wr_cnt;

  logic                    rd_pick_d_c;
  logic [31:0]             pick_addr_c;
  logic [7:0]              pick_len_c;
  logic [1:0]              pick_step_raw_c;
  logic [1:0]              pick_step_c;
  logic [BEAT_CNT_W-1:0]   pick_target_c;
  logic [BEAT_CNT_W-1:0]   rd_cnt_inc_c;
  logic                    rd_beat_c;
  logic                    rd_last_c;

  // Read grant selection: the port not granted last wins a tie, data wins on reset.
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;
  assign rd_pick_d_c = (d_rd_req && i_rd_req) ? ~last_grant_d : d_rd_req;
`else
  assign rd_pick_d_c = d_rd_req;
`endif

  assign pick_addr_c     = rd_pick_d_c ? d_rd_addr : i_rd_addr;
  assign pick_len_c      = rd_pick_d_c ? d_rd_len  : i_rd_len;
  assign pick_step_raw_c = rd_pick_d_c ? d_rd_step : i_rd_step;
  assign pick_step_c     = (pick_step_raw_c == 2'd0) ? 2'd1 : pick_step_raw_c;
  assign pick_target_c   = (BEAT_CNT_W'(pick_len_c) + BEAT_CNT_W'(1)) * BEAT_CNT_W'(pick_step_c);

  assign rd_cnt_inc_c = rd_cnt + BEAT_CNT_W'(1);
  assign rd_beat_c    = (rd_state == R_BUSY) && bus_rd_data_ready;
  assign rd_last_c    = rd_beat_c && (rd_cnt_inc_c == rd_target);

  assign i_rd_valid = rd_beat_c && !grant_d;
  assign d_rd_valid = rd_beat_c &&  grant_d;
  assign i_rd_done  = rd_last_c && !grant_d;
  assign d_rd_done  = rd_last_c &&  grant_d;

  // Read FSM; the gap state forces axi_ar_en low so every transaction starts on a fresh edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state      <= R_IDLE;
      grant_d       <= 1'b0;
      rd_cnt        <= '0;
      rd_target     <= '0;
      rd_data       <= 32'd0;
      axi_ar_en     <= 1'b0;
      cpu_rd_addr   <= 32'd0;
      ar_burst_len  <= 8'd0;
      ar_burst_step <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d  <= 1'b0;
`endif
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (i_rd_req || d_rd_req) begin
            grant_d       <= rd_pick_d_c;
            cpu_rd_addr   <= pick_addr_c;
            ar_burst_len  <= pick_len_c;
            ar_burst_step <= pick_step_c;
            rd_target     <= pick_target_c;
            rd_cnt        <= '0;
            axi_ar_en     <= 1'b1;
            rd_state      <= R_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d  <= rd_pick_d_c;
`endif
          end
        end
        R_BUSY: begin
          if (rd_beat_c) begin
            rd_data <= cpu_rd_data;
            if (rd_last_c) begin
              rd_cnt    <= '0;
              axi_ar_en <= 1'b0;
              rd_state  <= R_GAP;
            end else begin
              rd_cnt <= rd_cnt_inc_c;
            end
          end
        end
        R_GAP: begin
          axi_ar_en <= 1'b0;
          rd_state  <= R_IDLE;
        end
        default: begin
          axi_ar_en <= 1'b0;
          rd_cnt    <= '0;
          rd_state  <= R_IDLE;
        end
      endcase
    end
  end

  assign cpu_wr_data = d_wr_data;
  assign d_wr_beat   = (wr_state == W_BUSY) && bus_wr_data_ready;
  assign d_wr_done   = (wr_state == W_BUSY) && bus_wr_data_finish;

  // Write FSM; completion follows the bus finish strobe, not the local beat count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state      <= W_IDLE;
      wr_cnt        <= '0;
      axi_aw_en     <= 1'b0;
      cpu_wr_addr   <= 32'd0;
      aw_burst_len  <= 8'd0;
      aw_burst_step <= 2'd0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (d_wr_req) begin
            cpu_wr_addr   <= d_wr_addr;
            aw_burst_len  <= d_wr_len;
            aw_burst_step <= (d_wr_step == 2'd0) ? 2'd1 : d_wr_step;
            wr_cnt        <= '0;
            axi_aw_en     <= 1'b1;
            wr_state      <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (d_wr_beat) begin
            wr_cnt <= wr_cnt + BEAT_CNT_W'(1);
          end
          if (bus_wr_data_finish) begin
            axi_aw_en <= 1'b0;
            wr_state  <= W_GAP;
          end
        end
        W_GAP: begin
          wr_cnt    <= '0;
          axi_aw_en <= 1'b0;
          wr_state  <= W_IDLE;
        end
        default: begin
          wr_cnt    <= '0;
          axi_aw_en <= 1'b0;
          wr_state  <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_bus_arbiter.md
AXI_BUS_ARBITER -- requirements
Module: axi_bus_arbiter

Interface
REQ-001 SHALL have parameter BEAT_CNT_W, default 10: width of the read/write beat counters. It must hold (255+1)*3 = 768.
REQ-002 SHALL have: clk, in, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have: reset, in, 1. Reset is asynchronous and active-low.
REQ-004 SHALL have: i_rd_req / d_rd_req, in, 1 each. Instruction-port and data-port read request; held high until the matching done.
REQ-005 SHALL have: i_rd_addr / d_rd_addr, in, 32; i_rd_len / d_rd_len, in, 8; i_rd_step / d_rd_step, in, 2. Burst start address, beats-1 per burst, and bursts per transaction.
REQ-006 SHALL have: rd_data, out, 32, the shared read data; i_rd_valid / d_rd_valid, out, 1, beat strobe to the granted port only.
REQ-007 SHALL have: i_rd_done / d_rd_done, out, 1, a one-cycle transaction-complete pulse.
REQ-008 SHALL have write inputs: d_wr_req 1, d_wr_addr 32, d_wr_data 32, d_wr_len 8, d_wr_step 2.
REQ-009 SHALL have write outputs: d_wr_beat, out, 1, beat accepted (advance data); d_wr_done, out, 1, complete pulse.
REQ-010 SHALL have bus-side outputs: axi_ar_en 1, cpu_rd_addr 32, ar_burst_len 8, ar_burst_step 2, axi_aw_en 1, cpu_wr_addr 32, cpu_wr_data 32, aw_burst_len 8, aw_burst_step 2.
REQ-011 SHALL have bus-side inputs: cpu_rd_data 32, bus_rd_data_ready 1, bus_wr_data_ready 1, bus_wr_data_finish 1.

Function
REQ-012 Read FSM SHALL use states R_IDLE, R_BUSY, R_GAP; the read and write paths SHALL be independent and may run concurrently.
REQ-013 R_IDLE with any rd_req SHALL select a grantee and latch its addr, len and step, all registered.
  - Without the configuration macro: data port wins.
  - Step 0 SHALL be latched as 1.
  - Beat target SHALL be (len+1)*step.
  - Next state is R_BUSY.
REQ-014 R_BUSY SHALL hold axi_ar_en=1 and drive the latched fields. Each bus_rd_data_ready SHALL:
  - register cpu_rd_data onto rd_data in the same cycle;
  - pulse the grantee's rd_valid combinationally;
  - increment the beat counter.
REQ-015 When a beat brings the count equal to the target, the FSM SHALL:
  - pulse the grantee's rd_done in that same cycle;
  - clear the counter;
  - enter R_GAP.
REQ-016 R_GAP SHALL last exactly one cycle with axi_ar_en=0, then go to R_IDLE. This guarantees a fresh rising edge for the next transaction.
REQ-017 A request arriving while the FSM is R_BUSY or R_GAP SHALL wait; no request SHALL be dropped.
REQ-018 bus_rd_data_ready outside R_BUSY SHALL be ignored: no valid, no count.
REQ-019 Write FSM SHALL use states W_IDLE, W_BUSY, W_GAP.
  - d_wr_req in W_IDLE SHALL latch addr, len and step (step 0 latched as 1), then go to W_BUSY.
  - W_BUSY SHALL hold axi_aw_en=1.
  - cpu_wr_data SHALL equal d_wr_data combinationally.
  - d_wr_beat SHALL equal bus_wr_data_ready in W_BUSY, else 0.
REQ-020 bus_wr_data_finish in W_BUSY SHALL pulse d_wr_done in the same cycle and move to W_GAP. W_GAP lasts one cycle, then W_IDLE.
REQ-021 The write beat counter SHALL count d_wr_beat. A finish arriving with the count not equal to (len+1)*step SHALL still complete the transaction (bus is authoritative). The counter SHALL clear in W_GAP.
REQ-022 Both FSMs SHALL treat an illegal state encoding as idle on the next edge.

Reset
REQ-023 On reset low, asynchronously, the design SHALL:
  - put both FSMs in idle;
  - clear counters;
  - clear grant and rd_data;
  - drive axi_ar_en, axi_aw_en and all valid/done/beat outputs to 0;
  - drive latched address/len/step outputs to 0.
REQ-024 Reset mid-transaction SHALL abandon it with no done pulse. After release the FSMs SHALL start from idle on the next request.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN selects the read arbitration policy.
  - Defined: when both ports request in R_IDLE, the port not granted last SHALL win. The last-grant flag resets to instruction, so data wins first.
  - Undefined: fixed data-port priority; the flag logic SHALL not be present.

Verification
REQ-026 i_rd_req alone, addr 0x1FC0_0000, len 7, step 1; 8 ready pulses. Expect:
  - axi_ar_en rises 1 cycle after the request;
  - 8 i_rd_valid pulses;
  - i_rd_done with the 8th pulse;
  - axi_ar_en low for exactly 1 cycle.
REQ-027 d_rd_req with len 3, step 2. Expect d_rd_done only on the 8th beat, with ar_burst_step=2 held throughout.
REQ-028 i and d read requests in the same cycle, both held for two transactions. Expect:
  - without macro: d, d, …, with i starved while d is held;
  - with ARB_ROUND_ROBIN_EN: d then i.
REQ-029 d_wr_req with len 3, step 1, concurrent with an i read. Expect:
  - 4 d_wr_beat pulses;
  - d_wr_done on bus_wr_data_finish;
  - read completes unaffected.
REQ-030 Reset asserted after 3 of 8 read beats. Expect:
  - all outputs 0 immediately;
  - no i_rd_done;
  - a new request after release is served from beat count 0.
REQ-031 Step 0 on a read request. Expect ar_burst_step=1 and done after len+1 beats.
